pipe_alu_rf_fwd: RTL and testbench
==================================

// Module: pipe_alu_rf_fwd
// PURPOSE
//  Parametrised 4-stage ALU datapath: operand fetch, execute, register
//  writeback and data-memory store.
//  - Carries a valid bit per stage.
//  - Optionally forwards in-flight results to operand fetch.
//  - Flags illegal opcodes.
//  Sits between the instruction issue logic and the data memory in the
//  datapath tile.
// PARAMETERS
//  DATA_W  16  datapath / register / memory word width
//  REG_AW   4  register index width (2**REG_AW registers)
//  MEM_AW   8  data memory address width (2**MEM_AW words)
// PORTS
//  clk         in   1        single rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        issue strobe; instruction sampled on clk rise
//  rs1, rs2    in   REG_AW   source register indices
//  rd          in   REG_AW   destination register index
//  func        in   4        opcode
//  addr        in   MEM_AW   store address
//  st          in   1        1 = store result to mem[addr]
//  zout        out  DATA_W   result leaving the writeback stage
//  zout_valid  out  1        zout holds a legal result this cycle
//  illegal     out  1        writeback-stage instruction had an illegal func
//  dbg_raddr   in   MEM_AW   debug memory read address
//  dbg_rdata   out  DATA_W   mem[dbg_raddr], combinational
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - All stage valids, zout, zout_valid, illegal = 0.
//  - All registers = 0. Memory is not cleared.
//  Pipeline (instruction sampled at edge k):
//  - S1 at k: operands A, B and rd/func/addr/st latched.
//  - S2 at k+1: Z computed and latched.
//  - S3 at k+2: regbank[rd] <= Z; zout, zout_valid, illegal updated.
//  - S4 at k+3: if st, mem[addr] <= Z.
//  - Throughput 1 instruction/clk; no backpressure; in_valid=0 inserts a bubble.
//  Opcodes (results truncated to DATA_W, two's complement wrap):
//  - 0 A+B | 1 A-B | 2 A*B (low half) | 3 A | 4 B | 5 A&B | 6 A|B
//  - 7 A^B | 8 -A | 9 -B | 10 A>>1 (logical) | 11 A<<1
//  - 12..15: illegal. Z=0, no regbank write, no store even if st=1.
//    At S3: illegal=1, zout=0, zout_valid=0.
//  Bubbles and stage valids:
//  - zout_valid/illegal are 1 only for the cycle after S3 captures a valid
//    instruction. Bubbles keep zout at its last value with zout_valid=0.
//  - Invalid stages never write regbank or mem.
//  Same-edge read/write:
//  - The S1 read and the S3 write of one register at the same edge: the read
//    returns the pre-write value unless forwarding is enabled.
//  Reset mid-operation:
//  - In-flight instructions are discarded; no regbank/mem write occurs after
//    rst_n falls.
//  - The first instruction accepted after rst_n rises sees all-zero registers.
//  Register 0 is an ordinary writable register.
// CONFIGURATION
//  PIPE_FWD_EN defined: S1 operand select per source, priority order:
//  - (1) S2 combinational Z if S2 valid, legal, and rd matches.
//  - (2) S3 latched Z if S3 valid, legal, and rd matches.
//  - (3) regbank.
//  - Dependent back-to-back instructions produce correct results.
//  PIPE_FWD_EN undefined:
//  - Operands come from regbank only.
//  - A consumer must issue >= 3 edges after its producer.
//  - Closer dependent consumers read the stale value; this is required
//    behaviour, not an error.
// TESTING
//  T1 reset:
//  - Hold rst_n=0, drive in_valid=1 -> zout=0, zout_valid=0, illegal=0.
//  - After release, func=3 rs1=5 -> zout=0.
//  T2 ALU sweep:
//  - Preload r1=0x8001, r2=0x0003; issue func 0..11 with rs1=1 rs2=2.
//  - Expect zout 0x8004, 0x7FFE, 0x8003, 0x8001, 0x0003, 0x0001, 0x8003,
//    0x8002, 0x7FFF, 0xFFFD, 0x4000, 0x0002, each 2 clk after its issue.
//  T3 hazard:
//  - r1=5, r2=7; issue ADD r3=r1+r2, then next clk ADD r4=r3+r3.
//  - PIPE_FWD_EN: zout=0x000C then 0x0018.
//  - Without it: 0x000C then 2*old r3 (0 after reset).
//  T4 illegal:
//  - func=13, rd=6, st=1, addr=0x10 -> illegal=1 for 1 clk, zout_valid=0.
//  - r6 and mem[0x10] unchanged (check via dbg_rdata).
//  T5 store:
//  - ADD st=1 addr=0xFF with bubbles around it -> dbg_raddr=0xFF returns
//    the sum from edge k+3 on; no other address modified.
//  T6 mid-flight reset:
//  - Issue 3 stores, assert rst_n at k+1 -> no mem writes, all regs read 0.

Source files
------------

// File: rtl/pipe_alu_rf_fwd.sv
// Four-stage ALU datapath: operand fetch, execute, register writeback, memory store.
// Build option PIPE_FWD_EN forwards in-flight results into operand fetch.
module pipe_alu_rf_fwd #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic [MEM_AW-1:0] addr,
    input  logic              st,
    output logic [DATA_W-1:0] zout,
    output logic              zout_valid,
    output logic              illegal,
    input  logic [MEM_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam int NREG = 1 << REG_AW;
    localparam int NMEM = 1 << MEM_AW;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_PASA = 4'd3,
        OP_PASB = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NEGA = 4'd8,
        OP_NEGB = 4'd9,
        OP_SHR  = 4'd10,
        OP_SHL  = 4'd11
    } op_e;

    function automatic logic is_legal(input logic [3:0] f);
        return (f < 4'd12);
    endfunction

    function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [3:0]        f);
        logic [DATA_W-1:0] r;
        case (f)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_PASA: r = a;
            OP_PASB: r = b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NEGA: r = -a;
            OP_NEGB: r = -b;
            OP_SHR:  r = {1'b0, a[DATA_W-1:1]};
            OP_SHL:  r = {a[DATA_W-2:0], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [NREG-1:0][DATA_W-1:0] regbank_q;
    logic [DATA_W-1:0]           mem_q [NMEM];

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    logic [REG_AW-1:0] s1_rd_q;
    logic [3:0]        s1_func_q;
    logic [MEM_AW-1:0] s1_addr_q;
    logic              s1_st_q;

    logic              s2_valid_q;
    logic              s2_legal_q;
    logic [DATA_W-1:0] s2_z_q;
    logic [REG_AW-1:0] s2_rd_q;
    logic [MEM_AW-1:0] s2_addr_q;
    logic              s2_st_q;

    logic              s3_we_q;
    logic [DATA_W-1:0] s3_z_q;
    logic [MEM_AW-1:0] s3_addr_q;

    logic [DATA_W-1:0] zout_q;
    logic [DATA_W-1:0] zout_d;
    logic              zout_valid_q;
    logic              zout_valid_d;
    logic              illegal_q;
    logic              illegal_d;

    logic              s1_legal_s;
    logic [DATA_W-1:0] alu_z_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic              s2_wr_s;

    // Execute-stage result; illegal opcodes produce zero.
    always_comb begin
        s1_legal_s = is_legal(s1_func_q);
        if (s1_legal_s) begin
            alu_z_s = alu(s1_a_q, s1_b_q, s1_func_q);
        end else begin
            alu_z_s = '0;
        end
    end

    assign s2_wr_s = s2_valid_q & s2_legal_q;

    // Operand fetch: the youngest in-flight producer wins when forwarding is built in.
    always_comb begin
        op_a_s = regbank_q[rs1];
        op_b_s = regbank_q[rs2];
`ifdef PIPE_FWD_EN
        if (s1_valid_q && s1_legal_s && (s1_rd_q == rs1)) begin
            op_a_s = alu_z_s;
        end else if (s2_wr_s && (s2_rd_q == rs1)) begin
            op_a_s = s2_z_q;
        end else begin
            op_a_s = regbank_q[rs1];
        end
        if (s1_valid_q && s1_legal_s && (s1_rd_q == rs2)) begin
            op_b_s = alu_z_s;
        end else if (s2_wr_s && (s2_rd_q == rs2)) begin
            op_b_s = s2_z_q;
        end else begin
            op_b_s = regbank_q[rs2];
        end
`endif
    end

    // Writeback-stage outputs; bubbles hold zout and drop the strobes.
    always_comb begin
        if (s2_valid_q) begin
            zout_d       = s2_legal_q ? s2_z_q : '0;
            zout_valid_d = s2_legal_q;
            illegal_d    = ~s2_legal_q;
        end else begin
            zout_d       = zout_q;
            zout_valid_d = 1'b0;
            illegal_d    = 1'b0;
        end
    end

    // Pipeline stage registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_rd_q      <= '0;
            s1_func_q    <= 4'd0;
            s1_addr_q    <= '0;
            s1_st_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_legal_q   <= 1'b0;
            s2_z_q       <= '0;
            s2_rd_q      <= '0;
            s2_addr_q    <= '0;
            s2_st_q      <= 1'b0;
            s3_we_q      <= 1'b0;
            s3_z_q       <= '0;
            s3_addr_q    <= '0;
            zout_q       <= '0;
            zout_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q    <= op_a_s;
                s1_b_q    <= op_b_s;
                s1_rd_q   <= rd;
                s1_func_q <= func;
                s1_addr_q <= addr;
                s1_st_q   <= st;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_legal_q <= s1_legal_s;
                s2_z_q     <= alu_z_s;
                s2_rd_q    <= s1_rd_q;
                s2_addr_q  <= s1_addr_q;
                s2_st_q    <= s1_st_q;
            end
            s3_we_q      <= s2_wr_s & s2_st_q;
            s3_z_q       <= s2_z_q;
            s3_addr_q    <= s2_addr_q;
            zout_q       <= zout_d;
            zout_valid_q <= zout_valid_d;
            illegal_q    <= illegal_d;
        end
    end

    // Register bank write from the writeback stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regbank_q <= '0;
        end else if (s2_wr_s) begin
            regbank_q[s2_rd_q] <= s2_z_q;
        end
    end

    // Data memory store; contents survive reset, but a reset clears the pending store.
    always_ff @(posedge clk) begin
        if (s3_we_q) begin
            mem_q[s3_addr_q] <= s3_z_q;
        end
    end

    assign dbg_rdata  = mem_q[dbg_raddr];
    assign zout       = zout_q;
    assign zout_valid = zout_valid_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_pipe_alu_rf_fwd.sv
// Directed bench for pipe_alu_rf_fwd: reset, ALU sweep, hazards, illegal ops, stores, mid-flight reset.
module tb_pipe_alu_rf_fwd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic        st;
    logic [15:0] zout;
    logic        zout_valid;
    logic        illegal;
    logic [7:0]  dbg_raddr;
    logic [15:0] dbg_rdata;

    int errors = 0;
    int checks = 0;

    logic [15:0][15:0] bank_v;
    logic [15:0]       sweep_exp [12];
    logic [15:0]       exp_b;
    logic [15:0]       exp_c;

    pipe_alu_rf_fwd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .func       (func),
        .addr       (addr),
        .st         (st),
        .zout       (zout),
        .zout_valid (zout_valid),
        .illegal    (illegal),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] d, input logic s, input logic [7:0] ad);
        in_valid = 1'b1;
        func     = f;
        rs1      = a1;
        rs2      = a2;
        rd       = d;
        st       = s;
        addr     = ad;
    endtask

    task automatic issue(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] d, input logic s, input logic [7:0] ad);
        drive(f, a1, a2, d, s, ad);
        step();
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        st       = 1'b0;
        step();
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a, input logic [15:0] exp);
        dbg_raddr = a;
        #1;
        chk16(tag, dbg_rdata, exp);
    endtask

    initial begin
        sweep_exp = '{16'h8004, 16'h7FFE, 16'h8003, 16'h8001, 16'h0003, 16'h0001,
                      16'h8003, 16'h8002, 16'h7FFF, 16'hFFFD, 16'h4000, 16'h0002};
        rst_n     = 1'b0;
        dbg_raddr = 8'h00;
        drive(4'd3, 4'd5, 4'd0, 4'd0, 1'b0, 8'h00);

        // T1: reset holds outputs low even with in_valid asserted
        repeat (3) step();
        chk16("rst_zout", zout, 16'h0000);
        chk1("rst_zvalid", zout_valid, 1'b0);
        chk1("rst_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        issue(4'd3, 4'd5, 4'd0, 4'd0, 1'b0, 8'h00);
        bubble();
        bubble();
        chk16("post_rst_r5", zout, 16'h0000);
        chk1("post_rst_valid", zout_valid, 1'b1);
        bubble();
        bubble();

        // T3: read-after-write hazards at distance 1, 2 and 3
        bank_v     = '0;
        bank_v[1]  = 16'h0005;
        bank_v[2]  = 16'h0007;
        force dut.regbank_q = bank_v;
        step();
        release dut.regbank_q;
`ifdef PIPE_FWD_EN
        exp_b = 16'h0018;
        exp_c = 16'h0013;
`else
        exp_b = 16'h0000;
        exp_c = 16'h0007;
`endif
        issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 8'h00);
        issue(4'd0, 4'd3, 4'd3, 4'd4, 1'b0, 8'h00);
        issue(4'd0, 4'd3, 4'd2, 4'd5, 1'b0, 8'h00);
        chk16("haz_producer", zout, 16'h000C);
        chk1("haz_producer_v", zout_valid, 1'b1);
        issue(4'd0, 4'd3, 4'd3, 4'd6, 1'b0, 8'h00);
        chk16("haz_dist1", zout, exp_b);
        bubble();
        chk16("haz_dist2", zout, exp_c);
        bubble();
        chk16("haz_dist3", zout, 16'h0018);
        bubble();
        bubble();

        // T2: ALU sweep, results streaming back to back
        bank_v     = '0;
        bank_v[1]  = 16'h8001;
        bank_v[2]  = 16'h0003;
        bank_v[6]  = 16'h1234;
        force dut.regbank_q = bank_v;
        step();
        release dut.regbank_q;
        for (int i = 0; i < 14; i++) begin
            if (i < 12) begin
                drive(4'(i), 4'd1, 4'd2, 4'd7, 1'b0, 8'h00);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 2) begin
                chk16($sformatf("alu_f%0d", i - 2), zout, sweep_exp[i-2]);
                chk1($sformatf("alu_v%0d", i - 2), zout_valid, 1'b1);
            end
        end
        bubble();

        // T4: illegal opcode writes neither register nor memory
        issue(4'd3, 4'd6, 4'd0, 4'd8, 1'b1, 8'h10);
        bubble();
        bubble();
        bubble();
        chk_mem("ill_prestore", 8'h10, 16'h1234);
        issue(4'd13, 4'd1, 4'd2, 4'd6, 1'b1, 8'h10);
        bubble();
        bubble();
        chk1("ill_flag", illegal, 1'b1);
        chk1("ill_zvalid", zout_valid, 1'b0);
        chk16("ill_zout", zout, 16'h0000);
        bubble();
        chk1("ill_flag_drop", illegal, 1'b0);
        bubble();
        chk_mem("ill_mem", 8'h10, 16'h1234);
        issue(4'd3, 4'd6, 4'd0, 4'd9, 1'b0, 8'h00);
        bubble();
        bubble();
        chk16("ill_r6", zout, 16'h1234);

        // T5: isolated store lands at the fourth edge, neighbours untouched
        issue(4'd3, 4'd6, 4'd0, 4'd8, 1'b1, 8'hFE);
        issue(4'd3, 4'd6, 4'd0, 4'd8, 1'b1, 8'hFF);
        issue(4'd3, 4'd6, 4'd0, 4'd8, 1'b1, 8'h00);
        bubble();
        bubble();
        bubble();
        bubble();
        chk_mem("st_pre_ff", 8'hFF, 16'h1234);
        issue(4'd0, 4'd1, 4'd2, 4'd10, 1'b1, 8'hFF);
        bubble();
        bubble();
        chk16("st_zout", zout, 16'h8004);
        chk_mem("st_before_k3", 8'hFF, 16'h1234);
        bubble();
        chk_mem("st_at_k3", 8'hFF, 16'h8004);
        chk16("st_zout_hold", zout, 16'h8004);
        chk1("st_bubble_v", zout_valid, 1'b0);
        chk_mem("st_nb_fe", 8'hFE, 16'h1234);
        chk_mem("st_nb_00", 8'h00, 16'h1234);
        bubble();

        // T6: reset while stores are in flight
        issue(4'd3, 4'd1, 4'd0, 4'd8, 1'b1, 8'h20);
        issue(4'd3, 4'd1, 4'd0, 4'd8, 1'b1, 8'h21);
        issue(4'd3, 4'd1, 4'd0, 4'd8, 1'b1, 8'h22);
        bubble();
        bubble();
        bubble();
        chk_mem("mr_pre20", 8'h20, 16'h8001);
        issue(4'd4, 4'd0, 4'd2, 4'd11, 1'b1, 8'h20);
        issue(4'd4, 4'd0, 4'd2, 4'd12, 1'b1, 8'h21);
        rst_n = 1'b0;
        issue(4'd4, 4'd0, 4'd2, 4'd13, 1'b1, 8'h22);
        bubble();
        bubble();
        chk16("mr_zout", zout, 16'h0000);
        chk1("mr_zvalid", zout_valid, 1'b0);
        rst_n = 1'b1;
        bubble();
        bubble();
        chk_mem("mr_mem20", 8'h20, 16'h8001);
        chk_mem("mr_mem21", 8'h21, 16'h8001);
        chk_mem("mr_mem22", 8'h22, 16'h8001);
        issue(4'd3, 4'd1, 4'd0, 4'd14, 1'b0, 8'h00);
        issue(4'd4, 4'd0, 4'd2, 4'd14, 1'b0, 8'h00);
        issue(4'd3, 4'd6, 4'd0, 4'd14, 1'b0, 8'h00);
        chk16("mr_r1", zout, 16'h0000);
        chk1("mr_r1_v", zout_valid, 1'b1);
        bubble();
        chk16("mr_r2", zout, 16'h0000);
        bubble();
        chk16("mr_r6", zout, 16'h0000);
        bubble();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
